// File: rtl/tlp_dma_writer.sv
//============================================================================
// Module      : tlp_dma_writer
// Description : FPGA->Host DMA transmitter. Packs a 64-bit payload stream
//               into MWr64 (4DW header) TLPs on the TLP-level tx pipe.
//               Each TLP is two header qwords followed by TLP_QW payload
//               qwords passed straight through from the source.
// Options     : `define TLP_COUNT_EN adds tlpCount_out, a free-running count
//               of TLPs whose EOP beat was accepted since reset.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tlp_dma_writer #(
   parameter int TLP_QW = 16
) (
   input  logic        pcieClk_in,
   input  logic        pcieRst_in,
   input  logic [15:0] cfgBusDev_in,
   input  logic [63:0] dmaBase_in,
   input  logic [15:0] dmaNumTlps_in,
   input  logic        dmaStart_in,
   output logic        dmaBusy_out,
   output logic        dmaDone_out,
   input  logic [63:0] srcData_in,
   input  logic        srcValid_in,
   output logic        srcReady_out,
`ifdef TLP_COUNT_EN
   output logic [31:0] tlpCount_out,
`endif
   output logic [63:0] txData_out,
   output logic        txSOP_out,
   output logic        txEOP_out,
   output logic        txValid_out,
   input  logic        txReady_in
);

   // Payload beat counter width; at least one bit even for single-qword TLPs.
   localparam int                 BEAT_W    = (TLP_QW > 1) ? $clog2(TLP_QW) : 1;
   localparam logic [BEAT_W-1:0]  BEAT_LAST = BEAT_W'(TLP_QW - 1);
   // Length field is in DWs: two DWs per payload qword.
   localparam logic [9:0]         LEN_DW    = 10'(2 * TLP_QW);
   // Byte stride between consecutive TLP start addresses.
   localparam logic [63:0]        ADDR_STEP = 64'(TLP_QW * 8);
   // MWr with 64-bit address: fmt=3'b011 (4DW header, with data), type=0.
   localparam logic [2:0]         FMT_MWR64 = 3'b011;
   localparam logic [4:0]         TYPE_MWR  = 5'b00000;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HDR0 = 2'd1,
      ST_HDR1 = 2'd2,
      ST_DATA = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [63:0]       addr_q, addr_d;
   logic [15:0]       remain_q, remain_d;
   logic [7:0]        tag_q, tag_d;
   logic [BEAT_W-1:0] beat_q, beat_d;
   logic              done_q, done_d;

   logic              last_beat_w;
   logic              tx_fire_w;
   logic              eop_fire_w;
   logic [31:0]       hdr_dw0_w;
   logic [31:0]       hdr_dw1_w;
   logic              unused_base_w;

   // The low three address bits are forced to zero (qword aligned).
   assign unused_base_w = ^dmaBase_in[2:0];

   assign last_beat_w = (beat_q == BEAT_LAST);

   // A beat is accepted when the tx pipe takes it; header beats are always
   // valid, payload beats are valid only when the source offers data.
   assign tx_fire_w = txReady_in &&
                      ((state_q == ST_HDR0) || (state_q == ST_HDR1) ||
                       ((state_q == ST_DATA) && srcValid_in));

   assign eop_fire_w = tx_fire_w && (state_q == ST_DATA) && last_beat_w;

   // TC, attributes, TD, EP and AT are all left at zero.
   assign hdr_dw0_w = {FMT_MWR64, TYPE_MWR, 14'd0, LEN_DW};
   assign hdr_dw1_w = {cfgBusDev_in, tag_q, 4'hF, 4'hF};

   assign dmaBusy_out = (state_q != ST_IDLE);
   assign dmaDone_out = done_q;

   // State and datapath registers, all cleared by reset.
   always_ff @(posedge pcieClk_in) begin
      if (pcieRst_in) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         remain_q <= '0;
         tag_q    <= '0;
         beat_q   <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         remain_q <= remain_d;
         tag_q    <= tag_d;
         beat_q   <= beat_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic and tx/source handshake outputs.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      remain_d     = remain_q;
      tag_d        = tag_q;
      beat_d       = beat_q;
      done_d       = 1'b0;
      txData_out   = '0;
      txSOP_out    = 1'b0;
      txEOP_out    = 1'b0;
      txValid_out  = 1'b0;
      srcReady_out = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (dmaStart_in) begin
               addr_d   = {dmaBase_in[63:3], 3'b000};
               remain_d = dmaNumTlps_in;
               beat_d   = '0;
               if (dmaNumTlps_in == 16'd0) begin
                  // Empty job: report completion without touching the pipe.
                  done_d = 1'b1;
               end else begin
                  state_d = ST_HDR0;
               end
            end
         end

         ST_HDR0: begin
            txValid_out = 1'b1;
            txSOP_out   = 1'b1;
            txData_out  = {hdr_dw1_w, hdr_dw0_w};
            if (tx_fire_w) begin
               state_d = ST_HDR1;
            end
         end

         ST_HDR1: begin
            // DW2 carries the upper address half, DW3 the lower half.
            txValid_out = 1'b1;
            txData_out  = {addr_q[31:0], addr_q[63:32]};
            if (tx_fire_w) begin
               state_d = ST_DATA;
               beat_d  = '0;
            end
         end

         ST_DATA: begin
            // Payload flows through combinationally; backpressure from the
            // tx pipe goes straight back to the source.
            txValid_out  = srcValid_in;
            txData_out   = srcData_in;
            txEOP_out    = last_beat_w;
            srcReady_out = txReady_in;
            if (eop_fire_w) begin
               beat_d   = '0;
               tag_d    = tag_q + 8'd1;
               addr_d   = addr_q + ADDR_STEP;
               remain_d = remain_q - 16'd1;
               if (remain_q == 16'd1) begin
                  state_d = ST_IDLE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ST_HDR0;
               end
            end else if (tx_fire_w) begin
               beat_d = beat_q + BEAT_W'(1);
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef TLP_COUNT_EN
   logic [31:0] count_q;

   // Running count of completed TLPs; wraps naturally at 2^32.
   always_ff @(posedge pcieClk_in) begin
      if (pcieRst_in) begin
         count_q <= '0;
      end else if (eop_fire_w) begin
         count_q <= count_q + 32'd1;
      end
   end

   assign tlpCount_out = count_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_tlp_dma_writer.sv
//============================================================================
// Module      : tb_tlp_dma_writer
// Description : Self-checking bench for tlp_dma_writer. Expected TLP
//               streams are built from header field rules and the
//               sequence of source qwords.
// Revision    : 1.0 - initial release
//============================================================================
`default_nettype none

module tb_tlp_dma_writer;

   localparam int TLP_QW = 16;
   localparam int NBEAT  = TLP_QW + 2;

   typedef struct packed {
      logic        sop;
      logic        eop;
      logic [63:0] d;
   } bt_t;

   logic        clk = 1'b0;
   logic        pcie_rst = 1'b1;
   logic [15:0] busdev = 16'h0000;
   logic [63:0] dma_base = '0;
   logic [15:0] dma_num = '0;
   logic        dma_start = 1'b0;
   logic        busy, done;
   logic [63:0] src_data = '0;
   logic        src_valid = 1'b0;
   logic        src_ready;
   logic [63:0] tx_data;
   logic        tx_sop, tx_eop, tx_valid;
   logic        tx_ready = 1'b0;
`ifdef TLP_COUNT_EN
   logic [31:0] tlp_count;
`endif

   always #5 clk = ~clk;

   tlp_dma_writer #(.TLP_QW(TLP_QW)) dut (
      .pcieClk_in    (clk),
      .pcieRst_in    (pcie_rst),
      .cfgBusDev_in  (busdev),
      .dmaBase_in    (dma_base),
      .dmaNumTlps_in (dma_num),
      .dmaStart_in   (dma_start),
      .dmaBusy_out   (busy),
      .dmaDone_out   (done),
      .srcData_in    (src_data),
      .srcValid_in   (src_valid),
      .srcReady_out  (src_ready),
`ifdef TLP_COUNT_EN
      .tlpCount_out  (tlp_count),
`endif
      .txData_out    (tx_data),
      .txSOP_out     (tx_sop),
      .txEOP_out     (tx_eop),
      .txValid_out   (tx_valid),
      .txReady_in    (tx_ready)
   );

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   logic [63:0] src_vals[$];
   int          src_ptr = 0;
   bit          src_hold = 1'b0;
   bit          pend_valid = 1'b0;
   bt_t         pend_beat;
   bt_t         got[$];
   int          got_cyc[$];
   int          done_cyc = -1;
   logic        done_busy = 1'b0;
   int          m_tag = 0;
   int          m_count = 0;

   function automatic void check(string tag, logic [127:0] obs, logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endfunction

   function automatic void ensure_src(int idx);
      while (src_vals.size() <= idx) src_vals.push_back({$urandom, $urandom});
   endfunction

   // One clock cycle: drive inputs on the falling edge, sample just after.
   task automatic tick(input bit rr, input bit rv, input bit st, input bit rs);
      @(negedge clk);
      pcie_rst  = rs;
      dma_start = st;
      tx_ready  = rr ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!src_hold) src_valid = rv ? ($urandom_range(0, 2) != 0) : 1'b1;
      ensure_src(src_ptr);
      src_data = src_vals[src_ptr];
      #1;
      cyc++;
      if (pend_valid) begin
         check("hold_valid", tx_valid, 1'b1);
         check("hold_beat", {tx_sop, tx_eop, tx_data}, pend_beat);
      end
      pend_valid = tx_valid && !tx_ready && !rs;
      pend_beat  = '{tx_sop, tx_eop, tx_data};
      if (tx_valid && tx_ready && !rs) begin
         got.push_back('{tx_sop, tx_eop, tx_data});
         got_cyc.push_back(cyc);
      end
      if (src_valid && src_ready) src_ptr++;
      src_hold = src_valid && !src_ready;
      if (done) begin
         done_cyc  = cyc;
         done_busy = busy;
      end
   endtask

   task automatic check_idle(input string nm);
      check({nm, "_txValid"}, tx_valid, 1'b0);
      check({nm, "_txSOP"}, tx_sop, 1'b0);
      check({nm, "_txEOP"}, tx_eop, 1'b0);
      check({nm, "_txData"}, tx_data, 64'h0);
      check({nm, "_srcReady"}, src_ready, 1'b0);
      check({nm, "_busy"}, busy, 1'b0);
      check({nm, "_done"}, done, 1'b0);
`ifdef TLP_COUNT_EN
      check({nm, "_tlpCount"}, tlp_count, 32'd0);
`endif
   endtask

   task automatic apply_reset(input string nm);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);
      check_idle(nm);
      m_tag   = 0;
      m_count = 0;
   endtask

   // Run one DMA job and compare the tx stream with the expected TLPs.
   task automatic run_job(input logic [63:0] b, input int n, input bit rr,
                          input bit rv, input bit poke, input string nm);
      bt_t         exp_q[$];
      int          pay0;
      int          budget;
      int          start_cyc;
      int          last;
      logic [63:0] a;
      pay0 = src_ptr;
      ensure_src(pay0 + n * TLP_QW);
      for (int t = 0; t < n; t++) begin
         a = (b & ~64'h7) + 64'(t) * 64'(TLP_QW * 8);
         exp_q.push_back('{1'b1, 1'b0,
                           {busdev, 8'((m_tag + t) % 256), 8'hFF,
                            32'h6000_0000 | 32'(2 * TLP_QW)}});
         exp_q.push_back('{1'b0, 1'b0, {a[31:0], a[63:32]}});
         for (int i = 0; i < TLP_QW; i++)
            exp_q.push_back('{1'b0, (i == TLP_QW - 1), src_vals[pay0 + t * TLP_QW + i]});
      end

      got.delete();
      got_cyc.delete();
      done_cyc  = -1;
      dma_base  = b;
      dma_num   = 16'(n);
      tick(rr, rv, 1, 0);
      start_cyc = cyc;
      tick(rr, rv, 0, 0);
      // Inputs are only sampled on the accepted start; scramble them now.
      dma_base = {$urandom, $urandom};
      dma_num  = 16'($urandom_range(1, 9));
      check({nm, "_lat_valid"}, tx_valid, (n != 0));
      check({nm, "_lat_sop"}, tx_sop, (n != 0));
      check({nm, "_lat_busy"}, busy, (n != 0));

      budget = n * NBEAT * 8 + 40;
      for (int k = 0; k < budget && done_cyc < 0; k++) tick(rr, rv, poke && (k == 3), 0);

      if (done_cyc < 0) check({nm, "_timeout"}, 1'b0, 1'b1);
      check({nm, "_beat_count"}, got.size(), exp_q.size());
      for (int j = 0; j < got.size() && j < exp_q.size(); j++)
         check({nm, "_beat"}, got[j], exp_q[j]);
      if (got.size() > 0) begin
         last = got_cyc[got.size() - 1];
         check({nm, "_done_timing"}, done_cyc, last + 1);
      end else begin
         check({nm, "_done_timing"}, done_cyc, start_cyc + 1);
      end
      check({nm, "_busy_at_done"}, done_busy, 1'b0);
      if (!rr && !rv && n > 0 && got.size() == exp_q.size())
         check({nm, "_back_to_back"}, got_cyc[got.size() - 1] - got_cyc[0], n * NBEAT - 1);

      tick(rr, rv, 0, 0);
      check({nm, "_done_pulse"}, done, 1'b0);
      tick(rr, rv, 0, 0);
      check({nm, "_post_valid"}, tx_valid, 1'b0);
      check({nm, "_post_count"}, got.size(), exp_q.size());

      m_tag   = (m_tag + n) % 256;
      m_count = m_count + n;
`ifdef TLP_COUNT_EN
      check({nm, "_tlpCount"}, tlp_count, 32'(m_count));
`endif
   endtask

   initial begin
      apply_reset("reset");
      busdev = 16'hBEEF;

      // Single TLP, fixed header values.
      run_job(64'h0000_0001_0000_0000, 1, 0, 0, 0, "t1");
      if (got.size() >= 2) begin
         check("t1_hdr0", got[0], {1'b1, 1'b0, 64'hBEEF_00FF_6000_0020});
         check("t1_hdr1", got[1], {1'b0, 1'b0, 64'h0000_0000_0000_0001});
      end

      // Three back-to-back TLPs, address stepping.
      run_job(64'h0000_0000_0000_1000, 3, 0, 0, 0, "t2");
      if (got.size() >= 3 * NBEAT) begin
         check("t2_addr0", got[1].d, 64'h0000_1000_0000_0000);
         check("t2_addr1", got[NBEAT + 1].d, 64'h0000_1080_0000_0000);
         check("t2_addr2", got[2 * NBEAT + 1].d, 64'h0000_1100_0000_0000);
      end

      // Random backpressure and source gaps; low base bits ignored.
      run_job({$urandom, $urandom_range(0, 255), 24'h0} | 64'h5, 4, 1, 1, 0, "t3");
      // Address wrap past 2^64.
      run_job(64'hFFFF_FFFF_FFFF_FF00, 3, 1, 1, 0, "addr_wrap");
      // Empty job.
      run_job(64'h0000_0000_0000_5000, 0, 0, 0, 0, "zero");
      // Start while busy is ignored.
      run_job(64'h0000_0000_0000_6000, 2, 0, 1, 1, "poke");

      // Reset during payload beat 5.
      got.delete();
      dma_base = 64'h0000_0000_0000_2000;
      dma_num  = 16'd2;
      tick(0, 0, 1, 0);
      for (int k = 0; k < 40 && got.size() < 7; k++) tick(0, 0, 0, 0);
      check("rst_reach_beat5", got.size(), 7);
      tick(0, 0, 0, 1);
      tick(0, 0, 0, 0);
      check_idle("rst_mid");
      m_tag   = 0;
      m_count = 0;

      // Fresh tag after reset, then tag wrap on the 257th TLP.
      run_job(64'h0000_0000_0001_0000, 257, 0, 0, 0, "tagwrap");
      if (got.size() == 257 * NBEAT) begin
         check("tagwrap_first", got[0].d[47:40], 8'd0);
         check("tagwrap_257th", got[256 * NBEAT].d[47:40], 8'd0);
         check("tagwrap_hdr_dw0", got[0].d[31:0], 32'h6000_0020);
      end

      // Two jobs from a clean reset: 3 + 2 TLPs.
      apply_reset("reset2");
      run_job(64'h0000_0000_0000_8000, 3, 1, 1, 0, "jobA");
      run_job(64'h0000_0000_0000_9000, 2, 1, 0, 0, "jobB");
`ifdef TLP_COUNT_EN
      check("tlpCount_total", tlp_count, 32'd5);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

`default_nettype wire
